// File: rtl/ervp_spsram_arb_pkg.sv
// Shared definitions for the single-port SRAM cell arbiter: owner encoding,
// lock-bound default and lock-counter sizing.
package ervp_spsram_arb_pkg;

    typedef enum logic {
        OWNER_RQ0 = 1'b0,
        OWNER_RQ1 = 1'b1
    } owner_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    localparam int MAX_LOCK_DEFAULT = 16;

    // Counter must hold the value MAX_LOCK itself, hence the extra bit.
    function automatic int lock_cnt_width(input int max_lock);
        return $clog2(max_lock) + 1;
    endfunction

endpackage

// File: rtl/ervp_spsram_cell_arbiter_if.sv
// One requester port of the SRAM cell arbiter: request/payload from the
// master, grant and read return from the arbiter.
interface ervp_spsram_cell_arbiter_if #(
    parameter int BW_INDEX    = 15,
    parameter int BW_DATA     = 32,
    parameter int BW_BYTE_WEN = BW_DATA / 8
);
    logic                   req;
    logic                   lock;
    logic                   write;
    logic [BW_INDEX-1:0]    index;
    logic [BW_BYTE_WEN-1:0] wbyte;
    logic [BW_DATA-1:0]     wdata;
    logic                   grant;
    logic                   rvalid;
    logic [BW_DATA-1:0]     rdata;

    modport master (
        output req, lock, write, index, wbyte, wdata,
        input  grant, rvalid, rdata
    );

    modport slave (
        input  req, lock, write, index, wbyte, wdata,
        output grant, rvalid, rdata
    );
endinterface

// File: rtl/ervp_rr_lock_arbiter2.sv
// Two-way round-robin grant with a bounded lock that lets one requester keep
// the cell for back-to-back accesses while the other waits.
//
//   state     | meaning
//   ST_IDLE   | no lock held; contention resolved by last_ptr round-robin
//   ST_LOCKED | owner keeps the grant until it drops req/lock or the bound hits
module ervp_rr_lock_arbiter2
    import ervp_spsram_arb_pkg::*;
#(
    parameter int MAX_LOCK    = MAX_LOCK_DEFAULT,
    parameter int BW_LOCK_CNT = lock_cnt_width(MAX_LOCK)
) (
    input  logic       clk,
    input  logic       rstnn,
    input  logic       stall,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] grant,
    output logic       gnt_idx,
    output logic       owner,
    output logic       locked
);
    localparam logic [BW_LOCK_CNT-1:0] LOCK_MAX = BW_LOCK_CNT'(MAX_LOCK);
    localparam logic [BW_LOCK_CNT-1:0] LOCK_ONE = BW_LOCK_CNT'(1);

    lock_state_e             state_q, state_d;
    owner_e                  owner_q, owner_d;
    owner_e                  last_ptr_q, last_ptr_d;
    logic [BW_LOCK_CNT-1:0]  lock_cnt_q, lock_cnt_d;
    logic                    pick;

    always_comb begin
        grant = 2'b00;
        pick  = 1'b0;
        if (!stall) begin
            unique case (req)
                2'b01: grant = 2'b01;
                2'b10: grant = 2'b10;
                2'b11: begin
                    if (state_q == ST_LOCKED)
                        pick = (lock_cnt_q == LOCK_MAX) ? ~owner_q : owner_q;
                    else
                        pick = ~last_ptr_q;
                    grant = pick ? 2'b10 : 2'b01;
                end
                default: grant = 2'b00;
            endcase
        end
    end

    assign gnt_idx = grant[1];

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_ptr_d = last_ptr_q;
        lock_cnt_d = lock_cnt_q;
        if (!stall) begin
            if (grant != 2'b00) begin
                last_ptr_d = owner_e'(gnt_idx);
                owner_d    = owner_e'(gnt_idx);
                if (state_q == ST_LOCKED && gnt_idx == owner_q && lock[gnt_idx]) begin
                    if (req[~gnt_idx] && lock_cnt_q != LOCK_MAX)
                        lock_cnt_d = lock_cnt_q + LOCK_ONE;
                end else if (lock[gnt_idx]) begin
                    // Fresh lock, possibly right after a forced switch.
                    state_d    = ST_LOCKED;
                    lock_cnt_d = req[~gnt_idx] ? LOCK_ONE : '0;
                end else begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end
            end else if (state_q == ST_LOCKED) begin
                state_d    = ST_IDLE;
                lock_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstnn) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWNER_RQ0;
            last_ptr_q <= OWNER_RQ1;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_ptr_q <= last_ptr_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign owner  = owner_q;
    assign locked = (state_q == ST_LOCKED);

endmodule

// File: rtl/ervp_spsram_cell_arbiter.sv
// Shares one single-port SRAM cell between two requesters; muxes the granted
// access onto the cell and steers the 1-cycle read return to its issuer.
module ervp_spsram_cell_arbiter
    import ervp_spsram_arb_pkg::*;
#(
    parameter int BW_INDEX    = 15,
    parameter int BW_DATA     = 32,
    parameter int BW_BYTE_WEN = BW_DATA / 8,
    parameter int MAX_LOCK    = MAX_LOCK_DEFAULT,
    parameter int BW_LOCK_CNT = lock_cnt_width(MAX_LOCK)
) (
    input  logic                   clk,
    input  logic                   rstnn,
    ervp_spsram_cell_arbiter_if.slave rq0,
    ervp_spsram_cell_arbiter_if.slave rq1,
    output logic [BW_INDEX-1:0]    cell_index,
    output logic                   cell_enable,
    output logic                   cell_wenable,
    output logic [BW_BYTE_WEN-1:0] cell_wenable_byte,
    output logic [BW_DATA-1:0]     cell_wdata,
    output logic                   cell_renable,
    input  logic [BW_DATA-1:0]     cell_rdata,
    input  logic                   cell_stall,
    output logic                   owner,
    output logic                   locked
);
    logic [1:0] grant;
    logic       gnt_idx;
    logic       rvalid_q, rvalid_d;
    owner_e     rtag_q, rtag_d;

    ervp_rr_lock_arbiter2 #(
        .MAX_LOCK    (MAX_LOCK),
        .BW_LOCK_CNT (BW_LOCK_CNT)
    ) u_arb (
        .clk     (clk),
        .rstnn   (rstnn),
        .stall   (cell_stall),
        .req     ({rq1.req, rq0.req}),
        .lock    ({rq1.lock, rq0.lock}),
        .grant   (grant),
        .gnt_idx (gnt_idx),
        .owner   (owner),
        .locked  (locked)
    );

    assign rq0.grant = grant[0];
    assign rq1.grant = grant[1];

    always_comb begin
        cell_enable       = |grant;
        cell_index        = '0;
        cell_wenable      = 1'b0;
        cell_renable      = 1'b0;
        cell_wenable_byte = '0;
        cell_wdata        = '0;
        if (grant[0]) begin
            cell_index        = rq0.index;
            cell_wenable      = rq0.write;
            cell_renable      = ~rq0.write;
            cell_wenable_byte = rq0.write ? rq0.wbyte : '0;
            cell_wdata        = rq0.wdata;
        end else if (grant[1]) begin
            cell_index        = rq1.index;
            cell_wenable      = rq1.write;
            cell_renable      = ~rq1.write;
            cell_wenable_byte = rq1.write ? rq1.wbyte : '0;
            cell_wdata        = rq1.wdata;
        end
    end

    // Cell returns read data exactly one cycle after renable; tag it with the issuer.
    always_comb begin
        rvalid_d = cell_renable;
        rtag_d   = owner_e'(gnt_idx);
    end

    always_ff @(posedge clk) begin
        if (rstnn) begin
            rvalid_q <= 1'b0;
            rtag_q   <= OWNER_RQ0;
        end else begin
            rvalid_q <= rvalid_d;
            rtag_q   <= rtag_d;
        end
    end

    assign rq0.rvalid = rvalid_q & (rtag_q == OWNER_RQ0);
    assign rq1.rvalid = rvalid_q & (rtag_q == OWNER_RQ1);
    assign rq0.rdata  = cell_rdata;
    assign rq1.rdata  = cell_rdata;

endmodule

// File: tb/tb_ervp_spsram_cell_arbiter.sv
// Directed bench for the SRAM cell arbiter with a behavioural 1-cycle cell
// model; MAX_LOCK is reduced to 4 to exercise the lock bound quickly.
module tb_ervp_spsram_cell_arbiter;

    logic        clk;
    logic        rstnn;
    logic [14:0] cell_index;
    logic        cell_enable;
    logic        cell_wenable;
    logic [3:0]  cell_wenable_byte;
    logic [31:0] cell_wdata;
    logic        cell_renable;
    logic [31:0] cell_rdata;
    logic        cell_stall;
    logic        owner;
    logic        locked;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:32767];

    // Expected rq1 grant and locked flag per cycle of the lock-bound run.
    int lk_g [13] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    int lk_l [13] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};

    ervp_spsram_cell_arbiter_if rq0_if ();
    ervp_spsram_cell_arbiter_if rq1_if ();

    ervp_spsram_cell_arbiter #(
        .MAX_LOCK (4)
    ) dut (
        .clk               (clk),
        .rstnn             (rstnn),
        .rq0               (rq0_if),
        .rq1               (rq1_if),
        .cell_index        (cell_index),
        .cell_enable       (cell_enable),
        .cell_wenable      (cell_wenable),
        .cell_wenable_byte (cell_wenable_byte),
        .cell_wdata        (cell_wdata),
        .cell_renable      (cell_renable),
        .cell_rdata        (cell_rdata),
        .cell_stall        (cell_stall),
        .owner             (owner),
        .locked            (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cell_wenable)
            for (int b = 0; b < 4; b++)
                if (cell_wenable_byte[b])
                    mem[cell_index][b*8 +: 8] <= cell_wdata[b*8 +: 8];
        if (cell_renable)
            cell_rdata <= mem[cell_index];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic req, input logic lock, input logic write,
                        input logic [14:0] idx, input logic [3:0] wb, input logic [31:0] wd);
        rq0_if.req = req; rq0_if.lock = lock; rq0_if.write = write;
        rq0_if.index = idx; rq0_if.wbyte = wb; rq0_if.wdata = wd;
    endtask

    task automatic set1(input logic req, input logic lock, input logic write,
                        input logic [14:0] idx, input logic [3:0] wb, input logic [31:0] wd);
        rq1_if.req = req; rq1_if.lock = lock; rq1_if.write = write;
        rq1_if.index = idx; rq1_if.wbyte = wb; rq1_if.wdata = wd;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 32'hC0DE0000 | 32'(i);
        rstnn = 1'b1;
        cell_stall = 1'b0;
        set0(0, 0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0, 0);
        next();
        next();
        rstnn = 1'b0;
        #2;
        chk("rst_locked", locked, 0);
        chk("rst_owner", owner, 0);
        chk("rst_rvalid0", rq0_if.rvalid, 0);
        chk("rst_rvalid1", rq1_if.rvalid, 0);
        chk("rst_enable", cell_enable, 0);
        next();

        // Alternating contention, reads to 0x10 (rq0) and 0x20 (rq1).
        set0(1, 0, 0, 15'h10, 0, 0);
        set1(1, 0, 0, 15'h20, 0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                set0(0, 0, 0, 0, 0, 0);
                set1(0, 0, 0, 0, 0, 0);
            end
            #2;
            if (i < 3) begin
                chk("alt_grant0", rq0_if.grant, (i % 2 == 0));
                chk("alt_grant1", rq1_if.grant, (i % 2 == 1));
                chk("alt_index", cell_index, (i % 2 == 0) ? 32'h10 : 32'h20);
                chk("alt_renable", cell_renable, 1);
            end
            if (i > 0) begin
                chk("alt_rvalid0", rq0_if.rvalid, ((i - 1) % 2 == 0));
                chk("alt_rvalid1", rq1_if.rvalid, ((i - 1) % 2 == 1));
                chk("alt_rdata", cell_rdata, ((i - 1) % 2 == 0) ? 32'hC0DE0010 : 32'hC0DE0020);
            end
            next();
        end

        // Stall three cycles; rq0 was granted last, so rq1 must win on release.
        set0(1, 0, 0, 15'h10, 0, 0);
        set1(1, 0, 0, 15'h20, 0, 0);
        cell_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("stall_grant0", rq0_if.grant, 0);
            chk("stall_grant1", rq1_if.grant, 0);
            chk("stall_enable", cell_enable, 0);
            chk("stall_rvalid", rq0_if.rvalid | rq1_if.rvalid, 0);
            next();
        end
        cell_stall = 1'b0;
        #2;
        chk("resume_grant1", rq1_if.grant, 1);
        chk("resume_grant0", rq0_if.grant, 0);
        next();
        #2;
        chk("resume2_grant0", rq0_if.grant, 1);
        chk("resume_rvalid1", rq1_if.rvalid, 1);
        chk("resume_rdata1", cell_rdata, 32'hC0DE0020);
        next();
        set0(0, 0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0, 0);
        #2;
        chk("resume_rvalid0", rq0_if.rvalid, 1);
        chk("resume_rdata0", cell_rdata, 32'hC0DE0010);
        chk("resume_idle", cell_enable, 0);
        next();

        // Lone requester: rq1 reads 0x30..0x39 back to back.
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) set1(1, 0, 0, 15'(32'h30 + i), 0, 0);
            else        set1(0, 0, 0, 0, 0, 0);
            #2;
            chk("lone_grant1", rq1_if.grant, (i < 10));
            chk("lone_rvalid1", rq1_if.rvalid, (i > 0));
            chk("lone_rvalid0", rq0_if.rvalid, 0);
            if (i > 0) chk("lone_rdata", cell_rdata, 32'hC0DE0030 + 32'(i - 1));
            next();
        end
        #2;
        chk("lone_tail", rq1_if.rvalid, 0);
        next();

        // Byte write over 0x11223344, then read back through rq0.
        set1(1, 0, 1, 15'h5, 4'hF, 32'h11223344);
        #2;
        chk("bw_grant1", rq1_if.grant, 1);
        chk("bw_wenable", cell_wenable, 1);
        next();
        set1(1, 0, 1, 15'h5, 4'h5, 32'hAABBCCDD);
        #2;
        chk("bw_wbyte", cell_wenable_byte, 4'h5);
        chk("bw_wdata", cell_wdata, 32'hAABBCCDD);
        chk("bw_renable", cell_renable, 0);
        next();
        set1(0, 0, 0, 0, 0, 0);
        set0(1, 0, 0, 15'h5, 4'hF, 32'h0);
        #2;
        chk("rd_grant0", rq0_if.grant, 1);
        chk("rd_wbyte_forced0", cell_wenable_byte, 0);
        chk("rd_renable", cell_renable, 1);
        next();
        set0(0, 0, 0, 0, 0, 0);
        #2;
        chk("bw_rvalid0", rq0_if.rvalid, 1);
        chk("bw_rdata", rq0_if.rdata, 32'h11BB33DD);
        chk("bw_rvalid1", rq1_if.rvalid, 0);
        next();

        // Lock bound: rq0 req+lock, rq1 req, MAX_LOCK=4, rq0 was granted last.
        set0(1, 1, 0, 15'h40, 0, 0);
        set1(1, 0, 0, 15'h50, 0, 0);
        for (int i = 0; i < 13; i++) begin
            #2;
            chk("lock_grant1", rq1_if.grant, (lk_g[i] == 1));
            chk("lock_grant0", rq0_if.grant, (lk_g[i] == 0));
            chk("lock_locked", locked, (lk_l[i] == 1));
            if (i > 0) begin
                chk("lock_owner", owner, (lk_g[i-1] == 1));
                chk("lock_rvalid1", rq1_if.rvalid, (lk_g[i-1] == 1));
                chk("lock_rvalid0", rq0_if.rvalid, (lk_g[i-1] == 0));
                chk("lock_rdata", cell_rdata, (lk_g[i-1] == 1) ? 32'hC0DE0050 : 32'hC0DE0040);
            end
            next();
        end

        // Reset while rq0 holds the lock (count 2) with a read in flight.
        rstnn = 1'b1;
        #2;
        chk("mid_pre_rvalid0", rq0_if.rvalid, 1);
        chk("mid_pre_locked", locked, 1);
        next();
        rstnn = 1'b0;
        #2;
        chk("mid_rvalid0", rq0_if.rvalid, 0);
        chk("mid_rvalid1", rq1_if.rvalid, 0);
        chk("mid_locked", locked, 0);
        chk("mid_grant0", rq0_if.grant, 1);
        chk("mid_grant1", rq1_if.grant, 0);
        next();
        set0(0, 0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0, 0);
        #2;
        chk("post_rvalid0", rq0_if.rvalid, 1);
        chk("post_enable", cell_enable, 0);
        next();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ervp_spsram_cell_arbiter.md
Name: ervp_spsram_cell_arbiter

Overview:
Two-requester arbiter that shares one single-port SRAM cell (1-cycle synchronous read, byte write enables) between an AXI SRAM controller port and a second master such as a DMA or preload engine. Arbitration is round-robin, with an optional bounded lock for back-to-back bursts. Read data is routed back to the issuing requester one cycle after issue. The block sits between the requesters and the memory cell instance.

Parameters:
BW_INDEX, 15, cell word-index width
BW_DATA, 32, cell data width (multiple of 8)
BW_BYTE_WEN, BW_DATA/8, byte-enable width
MAX_LOCK, 16, max consecutive locked grants while the other requester waits (>=1)
BW_LOCK_CNT, log2(MAX_LOCK)+1, lock counter width

Ports:
clk  in  1  clock
rstnn  in  1  reset; synchronous, active-high
rqN_req  in  1  access request, N=0,1
rqN_lock  in  1  request to keep the grant next cycle
rqN_write  in  1  1=write, 0=read
rqN_index  in  BW_INDEX  word index
rqN_wbyte  in  BW_BYTE_WEN  byte write enables
rqN_wdata  in  BW_DATA  write data
rqN_grant  out  1  access issued this cycle
rqN_rvalid  out  1  read data valid (registered)
rqN_rdata  out  BW_DATA  read data
cell_index  out  BW_INDEX  to cell
cell_enable  out  1  cell access strobe
cell_wenable  out  1  write strobe
cell_wenable_byte  out  BW_BYTE_WEN  byte enables
cell_wdata  out  BW_DATA  write data
cell_renable  out  1  read strobe
cell_rdata  in  BW_DATA  synchronous read data, valid 1 cycle after renable
cell_stall  in  1  cell cannot accept an access this cycle
owner  out  1  requester granted in the most recent grant cycle
locked  out  1  lock currently held

Behaviour:
- Clock: one clock, clk. Reset: synchronous and active-high (rstnn high on a rising edge resets).
- Reset values:
  - last_ptr=1, so rq0 wins the first contention.
  - lock_cnt=0, locked=0, owner=0.
  - rvalid_q=0, rtag_q=0, so both rqN_rvalid=0.
  - Grant outputs go low at once because cell_stall and req gate them combinationally.
- Grant is combinational, with zero-cycle latency: a request is issued to the cell in the same cycle its grant is high.
- Grant rule, when cell_stall=0:
  - Only one requester asserts req: that requester is granted.
  - Both assert req and locked=1: the lock holder is granted, unless lock_cnt==MAX_LOCK, in which case the other requester is granted.
  - Both assert req and locked=0: the requester != last_ptr is granted.
- cell_stall=1: both grants are 0, cell_enable=0, and the state does not advance.
- Cell outputs are muxed from the granted requester.
  - cell_enable = any grant.
  - cell_wenable = grant & write.
  - cell_renable = grant & ~write.
  - cell_wenable_byte is forced to 0 on reads.
  - With no grant, all cell outputs are 0.
- Lock state machine:
  - IDLE to LOCKED: grant to rqN with rqN_lock=1. Set locked=1 and owner=N.
    - lock_cnt=1 if the other requester was waiting in that cycle, else 0.
  - LOCKED, holding: while the owner keeps req=1 and lock=1 and is granted, lock_cnt increments only in cycles where the other requester's req=1. It saturates at MAX_LOCK.
  - LOCKED to IDLE, on any of:
    - owner req=0;
    - owner lock=0 at grant;
    - a forced switch at lock_cnt==MAX_LOCK.
    Clear lock_cnt. A forced switch grants the other requester, and that grant may itself start a new lock.
- last_ptr updates to the granted index on every grant.
- Read return:
  - rvalid_q <= cell_renable; rtag_q <= granted index.
  - rqN_rvalid = rvalid_q & (rtag_q==N).
  - Both rqN_rdata = cell_rdata (unqualified; consumers qualify it with rvalid).
- Read data always returns exactly one cycle after issue. cell_stall does not delay the return.
- Write-then-read to the same index in consecutive cycles returns the new data; this relies on cell ordering, and the arbiter never reorders accesses.
- Reset during a lock or a pending read: state clears, and no rvalid appears in the cycle after reset.
- Requesters hold req and payload stable until granted. Deasserting req early is legal: the request is simply dropped.

Decomposition:
- Shared package ervp_spsram_arb_pkg holds the owner-index encoding, the MAX_LOCK default, and a lock-counter width function.
- One natural sub-module, ervp_rr_lock_arbiter2: grant, last_ptr, lock FSM and counter.
- The top level holds the cell mux and the read-tag pipeline.

Test Plan:
- Alternating contention: both req every cycle, lock=0, reads to index 0x10 and 0x20. Required: grants alternate rq0, rq1, rq0, …; each rvalid arrives on the correct port one cycle after its grant.
- Lock bound: rq0 req+lock continuous, rq1 req continuous, MAX_LOCK=4. Required: rq0 is granted 4 consecutive cycles after rq1 starts waiting, then rq1 is granted once; the pattern repeats.
- Stall: cell_stall=1 for 3 cycles with both requesting. Required: no grants, cell_enable=0, last_ptr unchanged; arbitration resumes in the same order afterwards.
- Byte write then read: rq1 writes 0xAABBCCDD to index 5 with wbyte=0b0101, over prior 0x11223344; rq0 then reads index 5. Required: rq0_rvalid=1 one cycle later with rdata=0x11BB33DD; rq1_rvalid stays 0.
- Reset mid-lock: rq0 is locked with lock_cnt=2 and a read is in flight when rstnn pulses high for one cycle. Required: next cycle rvalid=0 and locked=0; the first contention after reset grants rq0.
- Lone requester: only rq1 requests, 10 reads with lock=0. Required: granted every cycle; rq1_rvalid is high for 10 consecutive cycles, offset by one.
